// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding one shared W-bit register.
// A grant lasts while the owner keeps req and lock high, up to MAX_HOLD cycles.
// Every grant is followed by a one-cycle GAP, then the block returns to IDLE.
module shared_reg_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         lock,
   input  logic [N-1:0]         wr_en,
   input  logic [N*W-1:0]       wr_data,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner_id,
   output logic                 busy,
   output logic                 timeout,
   output logic [W-1:0]         q
);

   localparam int         LW        = $clog2(N);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t        state, state_nxt;
   logic [LW-1:0] ptr, ptr_nxt;
   logic [LW-1:0] sel, scan;
   logic          found;
   logic [7:0]    cnt, cnt_nxt;
   logic [N-1:0]  gnt_nxt;
   logic [LW-1:0] owner_nxt;
   logic          timeout_nxt;
   logic [W-1:0]  q_nxt;
   logic          owner_req, owner_lock, owner_wr, hold_end;
   logic [W-1:0]  owner_data;

   // Hold counter increment that sticks at its ceiling instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Only the current owner's request, lock and write port matter during OWN.
   assign owner_req  = req[owner_id];
   assign owner_lock = lock[owner_id];
   assign owner_wr   = wr_en[owner_id];
   assign owner_data = wr_data[owner_id*W +: W];
   assign hold_end   = (cnt == HOLD_LAST);
   assign busy       = |gnt;

   // Rotating priority scan: walk from ptr upward; the lowest offset that requests wins.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      scan  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         scan = ptr + LW'(k);
         if (req[scan]) begin
            sel   = scan;
            found = 1'b1;
         end
      end
   end

   // Next-state and next-output logic of the IDLE/OWN/GAP controller.
   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      owner_nxt   = owner_id;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
      q_nxt       = q;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_nxt    = OWN;
               gnt_nxt      = '0;
               gnt_nxt[sel] = 1'b1;
               owner_nxt    = sel;
               ptr_nxt      = sel + 1'b1;
               cnt_nxt      = '0;
            end
         end
         OWN: begin
            // The owner's write lands even on the edge that ends the grant.
            if (owner_wr) q_nxt = owner_data;
            cnt_nxt = sat_inc(cnt);
            if (!owner_req || !owner_lock || hold_end) begin
               state_nxt   = GAP;
               gnt_nxt     = '0;
               owner_nxt   = '0;
               // Only a forced revocation (owner still wants the register) is flagged.
               timeout_nxt = owner_req && owner_lock && hold_end;
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset wins over any pending write or grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         owner_id <= '0;
         ptr      <= '0;
         cnt      <= '0;
         timeout  <= 1'b0;
         q        <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         owner_id <= owner_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         timeout  <= timeout_nxt;
         q        <= q_nxt;
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: stimulus queues one expected record
// per grant; the monitor checks each grant's start, length and release state.
module tb_shared_reg_arbiter;

   localparam int N        = 4;
   localparam int W        = 8;
   localparam int MAX_HOLD = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, lock, wr_en;
   logic [N*W-1:0] wr_data;
   logic [N-1:0]   gnt;
   logic [1:0]     owner_id;
   logic           busy, timeout;
   logic [W-1:0]   q;

   shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .wr_en(wr_en),
      .wr_data(wr_data), .gnt(gnt), .owner_id(owner_id), .busy(busy),
      .timeout(timeout), .q(q)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  g;
      logic [31:0] len;
      logic [7:0]  qv;
      logic        to;
   } grant_t;

   grant_t exp_q[$];
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic logic [31:0] pack4(input logic [7:0] b3, input logic [7:0] b2,
                                         input logic [7:0] b1, input logic [7:0] b0);
      return {b3, b2, b1, b0};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_owner"}, owner_id, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_q"}, q, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; lock = '0; wr_en = '0; wr_data = '0;
      tick(2);
      check_reset("reset");
      rst = 1'b0;
   endtask

   // Monitor: sampled on the falling edge, away from the driving edge.
   grant_t cur;
   bit     active   = 1'b0;
   int     len_seen = 0;

   always @(negedge clk) begin
      if (!active) begin
         if (gnt != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", gnt, 0);
            end else begin
               cur = exp_q.pop_front();
               chk("gnt_start", gnt, cur.g);
               chk("owner_id", owner_id, onehot_idx(cur.g));
               chk("busy_high", busy, 1);
               active   = 1'b1;
               len_seen = 1;
            end
         end else if (!rst) begin
            chk("timeout_idle", timeout, 0);
         end
      end else if (gnt == cur.g) begin
         len_seen++;
         chk("timeout_during_grant", timeout, 0);
      end else begin
         chk("gnt_release", gnt, 0);
         chk("grant_len", len_seen, cur.len);
         chk("q_after_grant", q, cur.qv);
         chk("timeout_at_release", timeout, cur.to);
         chk("owner_idle", owner_id, 0);
         chk("busy_low", busy, 0);
         active = 1'b0;
      end
   end

   initial begin
      do_reset();

      // Single write in a one-cycle grant, then writes outside OWN are ignored.
      exp_q.push_back('{4'b0001, 32'd1, 8'hA5, 1'b0});
      req = 4'b0001; lock = '0;
      tick();
      wr_en = 4'b0001; wr_data = pack4(8'h00, 8'h00, 8'h00, 8'hA5);
      tick();
      req = '0; wr_en = 4'b1111; wr_data = pack4(8'hEE, 8'hEE, 8'hEE, 8'hEE);
      tick(3);
      chk("q_hold_outside_own", q, 8'hA5);
      wr_en = '0;

      // Round-robin with all requesters and no lock.
      do_reset();
      exp_q.push_back('{4'b0001, 32'd1, 8'h00, 1'b0});
      exp_q.push_back('{4'b0010, 32'd1, 8'h00, 1'b0});
      exp_q.push_back('{4'b0100, 32'd1, 8'h00, 1'b0});
      exp_q.push_back('{4'b1000, 32'd1, 8'h00, 1'b0});
      exp_q.push_back('{4'b0001, 32'd1, 8'h00, 1'b0});
      req = 4'b1111; lock = '0;
      tick(13);
      req = '0;
      tick(3);

      // Locked hold revoked at MAX_HOLD; requester 3 is next in line.
      do_reset();
      exp_q.push_back('{4'b0100, 32'd16, 8'h77, 1'b1});
      exp_q.push_back('{4'b1000, 32'd1, 8'h77, 1'b0});
      req = 4'b0100; lock = 4'b0100; wr_en = 4'b0100;
      wr_data = pack4(8'h00, 8'h77, 8'h00, 8'h00);
      tick();
      req = 4'b1101;
      tick(18);
      req = '0; lock = '0; wr_en = '0;
      tick(3);

      // Owner write lands; foreign writes during the grant are ignored.
      do_reset();
      exp_q.push_back('{4'b0010, 32'd3, 8'h3C, 1'b0});
      req = 4'b0010; lock = 4'b0010;
      tick();
      wr_en = 4'b0010; wr_data = pack4(8'h00, 8'h00, 8'h3C, 8'h00);
      tick();
      wr_en = 4'b0101; wr_data = pack4(8'hFF, 8'hFF, 8'h11, 8'hFF);
      tick();
      req = '0; lock = '0; wr_en = '0;
      tick(3);

      // Reset mid-grant with a coincident write, then normal arbitration.
      do_reset();
      exp_q.push_back('{4'b0010, 32'd2, 8'h00, 1'b0});
      exp_q.push_back('{4'b1000, 32'd1, 8'h00, 1'b0});
      req = 4'b0010; lock = 4'b0010;
      tick();
      wr_en = 4'b0010; wr_data = pack4(8'h00, 8'h00, 8'h5A, 8'h00);
      tick();
      chk("q_before_reset", q, 8'h5A);
      chk("gnt_before_reset", gnt, 4'b0010);
      rst = 1'b1; wr_data = pack4(8'h00, 8'h00, 8'h99, 8'h00);
      tick();
      check_reset("mid_grant");
      rst = 1'b0; req = 4'b1000; lock = '0; wr_en = '0;
      tick();
      req = '0;
      tick(3);

      // Voluntary release in the third OWN cycle; the next grant gets a full hold.
      do_reset();
      exp_q.push_back('{4'b0001, 32'd3, 8'h00, 1'b0});
      exp_q.push_back('{4'b0001, 32'd16, 8'h00, 1'b1});
      req = 4'b0001; lock = 4'b0001;
      tick(3);
      lock = '0;
      tick();
      lock = 4'b0001;
      tick(18);
      req = '0; lock = '0;
      tick(3);

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("monitor_idle", active, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
